// File: rtl/rc4_pkg.sv
// Shared constants and types for the RC4 key-search plaintext path.
package rc4_pkg;

  localparam int DEFAULT_MSG_LEN = 32;

  // Plaintext alphabet: space plus lowercase letters.
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LOW_A = 8'h61;
  localparam logic [7:0] ASCII_LOW_Z = 8'h7A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } checker_state_t;

endpackage : rc4_pkg

// File: rtl/ascii_char_check.sv
// Combinational plaintext-alphabet test for one byte; also used by the
// multi-core key-search arbiter.
module ascii_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_is_legal
);

  assign o_is_legal = (i_byte == ASCII_SPACE) ||
                      ((i_byte >= ASCII_LOW_A) && (i_byte <= ASCII_LOW_Z));

endmodule : ascii_char_check

// File: rtl/plaintext_checker_writer.sv
// Streams the decrypted message into the DE RAM one byte per cycle while
// checking every byte against the plaintext alphabet.
module plaintext_checker_writer
  import rc4_pkg::*;
#(
  parameter int MSG_LEN          = DEFAULT_MSG_LEN,
  parameter int ADDR_W           = $clog2(MSG_LEN),
  parameter bit ABORT_ON_INVALID = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        decrypted_data [MSG_LEN],
  output logic [ADDR_W-1:0] de_address,
  output logic [7:0]        de_data,
  output logic              de_wren,
  output logic              busy,
  output logic              done,
  output logic              key_valid,
  output logic [ADDR_W-1:0] bad_index
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

  checker_state_t    r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_de_address;
  logic [7:0]        r_de_data;
  logic              r_de_wren;
  logic              r_busy;
  logic              r_done;
  logic              r_key_valid;
  logic [ADDR_W-1:0] r_bad_index;

  checker_state_t    w_state_nxt;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic [ADDR_W-1:0] w_de_address_nxt;
  logic [7:0]        w_de_data_nxt;
  logic              w_de_wren_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_key_valid_nxt;
  logic [ADDR_W-1:0] w_bad_index_nxt;

  logic [7:0]        w_cur_byte;
  logic              w_cur_legal;
  logic [ADDR_W-1:0] w_next_idx;
  logic              w_last_write;

  // In WRITE, the byte on the RAM port this cycle is byte r_idx; it is
  // checked now and the following byte is registered at the same edge.
  assign w_cur_byte   = decrypted_data[r_idx];
  assign w_next_idx   = r_idx + 1'b1;
  assign w_last_write = (r_idx == LAST_IDX) || (ABORT_ON_INVALID && !w_cur_legal);

  ascii_char_check u_char_check (
    .i_byte     (w_cur_byte),
    .o_is_legal (w_cur_legal)
  );

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a variable unassigned and no latch is inferred.
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_de_address_nxt = r_de_address;
    w_de_data_nxt    = r_de_data;
    w_de_wren_nxt    = 1'b0;
    w_busy_nxt       = 1'b0;
    w_done_nxt       = 1'b0;
    w_key_valid_nxt  = r_key_valid;
    w_bad_index_nxt  = r_bad_index;

    if (abort) begin
      w_state_nxt     = IDLE;
      w_key_valid_nxt = 1'b0;
      w_bad_index_nxt = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            w_state_nxt      = WRITE;
            w_idx_nxt        = '0;
            w_de_address_nxt = '0;
            w_de_data_nxt    = decrypted_data[0];
            w_de_wren_nxt    = 1'b1;
            w_busy_nxt       = 1'b1;
            w_key_valid_nxt  = 1'b1;
            w_bad_index_nxt  = '0;
          end
        end

        WRITE: begin
          if (!w_cur_legal && r_key_valid) begin
            w_key_valid_nxt = 1'b0;
            w_bad_index_nxt = r_idx;
          end
          if (w_last_write) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
            if (w_key_valid_nxt) begin
              w_bad_index_nxt = LAST_IDX;
            end
          end else begin
            w_idx_nxt        = w_next_idx;
            w_de_address_nxt = w_next_idx;
            w_de_data_nxt    = decrypted_data[w_next_idx];
            w_de_wren_nxt    = 1'b1;
            w_busy_nxt       = 1'b1;
          end
        end

        // A start coinciding with the done pulse is dropped on purpose.
        DONE: w_state_nxt = IDLE;

        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_de_address <= '0;
      r_de_data    <= '0;
      r_de_wren    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_key_valid  <= 1'b0;
      r_bad_index  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // of the previous cycle regardless of statement order.
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_de_address <= w_de_address_nxt;
      r_de_data    <= w_de_data_nxt;
      r_de_wren    <= w_de_wren_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_key_valid  <= w_key_valid_nxt;
      r_bad_index  <= w_bad_index_nxt;
    end
  end

  assign de_address = r_de_address;
  assign de_data    = r_de_data;
  assign de_wren    = r_de_wren;
  assign busy       = r_busy;
  assign done       = r_done;
  assign key_valid  = r_key_valid;
  assign bad_index  = r_bad_index;

endmodule : plaintext_checker_writer
